bsa_ctrl: RTL and testbench
===========================

// Module: bsa_ctrl
// PURPOSE
//   Sequencer for the bit-serial adder (BSA). Accepts a parallel operand pair over a
//   valid/ready handshake and pulses the adder's Load. Counts WL+1 serial cycles and
//   deserialises sbit (LSB first, then carry) into a parallel (WL+1)-bit sum.
//   Presents the sum over a valid/ready handshake. Sits between the parallel datapath
//   and one BSA instance; one addition in flight at a time.
// PARAMETERS
//   WL    4             operand word length in bits; must match the attached BSA
//   CW    $clog2(WL+2)  bit-counter width, derived; not overridden
// PORTS
//   CLK        in   1     clock; all state changes on rising edge
//   RST        in   1     asynchronous, active-low reset
//   in_valid   in   1     operand pair a_in/b_in valid
//   in_ready   out  1     controller can accept an operand pair
//   a_in       in   WL    operand A
//   b_in       in   WL    operand B
//   bsa_a      out  WL    operand A to BSA .a (registered)
//   bsa_b      out  WL    operand B to BSA .b (registered)
//   bsa_load   out  1     drives BSA .Load
//   bsa_sbit   in   1     BSA .sbit serial sum bit
//   out_valid  out  1     sum valid
//   out_ready  in   1     consumer accepts sum
//   sum        out  WL+1  {carry, sum[WL-1:0]}
//   busy       out  1     high in any state except IDLE
// BEHAVIOUR
//   BSA contract: on an edge with Load=1, BSA captures a/b and clears its carry.
//     After that edge, sbit is sum bit 0 and advances one bit per edge.
//     Shifted-in bits are 0, so bit WL is the carry-out.
//   RST low: state=IDLE, in_ready=0 (1 from first edge after release), bsa_load=0,
//     bsa_a=bsa_b=0, out_valid=0, sum=0, busy=0, counter=0. Takes effect immediately.
//   FSM states: IDLE, LOAD, SHIFT, DONE.
//     IDLE:  in_ready=1. in_valid & in_ready at edge -> register a_in/b_in into bsa_a/bsa_b; go to LOAD.
//     LOAD:  bsa_load=1 for exactly one cycle; counter<=0; go to SHIFT.
//     SHIFT: each edge: sum <= {bsa_sbit, sum[WL:1]}; counter++.
//            At the edge where counter==WL (WL+1 bits taken): out_valid<=1; go to DONE.
//     DONE:  hold sum and out_valid. out_valid & out_ready at edge -> out_valid<=0; go to IDLE.
//   in_ready is registered; it is 0 in LOAD, SHIFT and DONE. No input queueing.
//   bsa_a/bsa_b are stable from the accept edge until the next accept.
//   bsa_load is a registered output, high only in LOAD.
//   Latency, accept edge to out_valid: WL+2 cycles; min turnaround per add: WL+4 cycles.
//   out_ready held high while entering DONE: one cycle in DONE, then IDLE.
//   Stalling out_ready holds DONE indefinitely; sum must not change.
//   in_valid during busy is ignored (not latched). a_in/b_in are don't-care when in_valid=0.
//   Arithmetic: sum = a_in + b_in, unsigned, exact in WL+1 bits; no overflow possible.
//   Reset mid-operation (any state) aborts: IDLE immediately, out_valid=0, partial sum discarded.
//   Illegal/unused state encodings recover to IDLE on the next edge.
// TESTING
//   1 Reset: hold RST=0 for 3 cycles, then release.
//     -> all outputs 0 during reset; in_ready=1 one edge after release; bsa_load never high.
//   2 WL=4, a=4'b1111, b=4'b1111, out_ready=1.
//     -> bsa_load pulses one cycle after accept; out_valid after 6 cycles; sum=5'b11110 (30).
//   3 a=4'd0, b=4'd0 -> sum=0; then a=4'd9, b=4'd5 -> sum=5'd14.
//     -> both in_ready gaps are exactly WL+3 cycles.
//   4 Backpressure: a=4'd7, b=4'd1, out_ready=0 for 10 cycles, in_valid held high with new operands.
//     -> sum stays 5'd8, in_ready=0, bsa_load stays 0.
//     -> raise out_ready: out_valid drops; next pair accepted the cycle after.
//   5 Reset mid-SHIFT: pulse RST low after 2 serial cycles of a=4'd3, b=4'd3.
//     -> out_valid=0, sum=0, busy=0 immediately; next add a=4'd2, b=4'd2 -> sum=5'd4.
//   6 Random: 200 random pairs, random out_ready.
//     -> scoreboard checks sum==a+b; no sum dropped or duplicated; bsa_load exactly once per accept.

Source files
------------

// File: rtl/bsa_ctrl.sv
// Sequencer for one bit-serial adder: accepts an operand pair, pulses Load,
// collects WL+1 serial sum bits LSB first and presents the parallel sum.
module bsa_ctrl #(
  parameter int WL = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WL-1:0] a_in,
  input  logic [WL-1:0] b_in,
  output logic [WL-1:0] bsa_a,
  output logic [WL-1:0] bsa_b,
  output logic          bsa_load,
  input  logic          bsa_sbit,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WL:0]   sum,
  output logic          busy
);

  // state | meaning
  // IDLE  | waiting for an operand pair, in_ready high
  // LOAD  | bsa_load high, adder captures operands and clears its carry
  // SHIFT | taking WL+1 serial bits into sum
  // DONE  | sum presented, waiting for out_ready

  localparam int CW = $clog2(WL + 2);
  localparam logic [CW-1:0] LAST = CW'(WL);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid && in_ready) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (count == LAST) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and Load outputs are registered copies of the next state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      bsa_load  <= 1'b0;
      out_valid <= 1'b0;
      bsa_a     <= '0;
      bsa_b     <= '0;
      sum       <= '0;
      count     <= '0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == IDLE);
      bsa_load  <= (state_nxt == LOAD);
      out_valid <= (state_nxt == DONE);
      if (state == IDLE && in_valid && in_ready) begin
        bsa_a <= a_in;
        bsa_b <= b_in;
      end
      if (state == LOAD) count <= '0;
      if (state == SHIFT) begin
        sum   <= {bsa_sbit, sum[WL:1]};
        count <= count + CW'(1);
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_bsa_ctrl.sv
// Bench for bsa_ctrl: a bit-serial adder model drives sbit, a transaction-level
// model predicts handshakes, Load and sums, checked every falling edge.
module tb_bsa_ctrl;
  localparam int WL = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          in_valid, in_ready;
  logic [WL-1:0] a_in, b_in, bsa_a, bsa_b;
  logic          bsa_load, bsa_sbit;
  logic          out_valid, out_ready;
  logic [WL:0]   sum;
  logic          busy;

  int n_cmp = 0, n_bad = 0;

  bsa_ctrl #(.WL(WL)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .bsa_a(bsa_a), .bsa_b(bsa_b),
    .bsa_load(bsa_load), .bsa_sbit(bsa_sbit), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Bit-serial adder: Load captures operands and clears carry, then one sum bit per edge.
  logic [WL-1:0] ra = '0, rb = '0;
  logic          rc = 1'b0;
  always @(posedge CLK) begin
    if (bsa_load) begin
      ra <= bsa_a;
      rb <= bsa_b;
      rc <= 1'b0;
    end else begin
      rc <= (ra[0] & rb[0]) | (ra[0] & rc) | (rb[0] & rc);
      ra <= ra >> 1;
      rb <= rb >> 1;
    end
  end
  assign bsa_sbit = ra[0] ^ rb[0] ^ rc;

  // Transaction model: m_k counts edges since the accept edge; sum due at WL+2.
  logic          m_active = 1'b0, m_ready = 1'b0;
  int            m_k = 0;
  logic [WL-1:0] m_a = '0, m_b = '0;
  logic [WL:0]   sb_q[$];
  int            n_acc = 0, n_done = 0, n_load = 0;
  logic [WL:0]   sb_exp;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_active = 1'b0;
      m_ready  = 1'b0;
      m_k      = 0;
      sb_q.delete();
    end else if (!m_active) begin
      if (m_ready && in_valid) begin
        m_active = 1'b1;
        m_ready  = 1'b0;
        m_k      = 0;
        m_a      = a_in;
        m_b      = b_in;
        sb_q.push_back({1'b0, a_in} + {1'b0, b_in});
        n_acc++;
      end else begin
        m_ready = 1'b1;
      end
    end else if (m_k == WL + 2) begin
      if (out_ready) begin
        n_done++;
        chk("sb_depth", 32'(sb_q.size()), 32'd1);
        if (sb_q.size() > 0) begin
          sb_exp = sb_q.pop_front();
          chk("sb_sum", 32'(sum), 32'(sb_exp));
        end
        m_active = 1'b0;
        m_ready  = 1'b1;
      end
    end else begin
      m_k++;
    end
  end

  int gap_cnt = 0, last_gap = 0;
  always @(negedge CLK) begin
    chk("in_ready", 32'(in_ready), 32'(m_ready));
    chk("busy", 32'(busy), 32'(m_active));
    chk("bsa_load", 32'(bsa_load), 32'(m_active && m_k == 0));
    chk("out_valid", 32'(out_valid), 32'(m_active && m_k == WL + 2));
    if (m_active && m_k == WL + 2 && sb_q.size() > 0) chk("sum", 32'(sum), 32'(sb_q[0]));
    if (m_active) begin
      chk("bsa_a", 32'(bsa_a), 32'(m_a));
      chk("bsa_b", 32'(bsa_b), 32'(m_b));
    end
    if (!RST) begin
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_bsa_a", 32'(bsa_a), 32'd0);
      chk("rst_bsa_b", 32'(bsa_b), 32'd0);
    end
    if (bsa_load) n_load++;
    if (!in_ready) gap_cnt++;
    else if (gap_cnt > 0) begin
      last_gap = gap_cnt;
      gap_cnt  = 0;
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic accept_pair(input logic [WL-1:0] a, input logic [WL-1:0] b);
    int n = 0;
    in_valid = 1'b1;
    a_in = a;
    b_in = b;
    while (!in_ready && n < 40) begin
      step();
      n++;
    end
    chk("accept_timeout", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output logic [WL:0] got, output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    chk("out_timeout", 32'(out_valid), 32'd1);
    got = sum;
    if (out_ready) step();
  endtask

  logic [WL:0] got;
  int          lat, acc0, done0, load0, n;
  logic        acc;

  initial begin
    RST = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;

    // Reset held three cycles, then released between edges.
    repeat (3) step();
    chk("t1_in_ready_rst", 32'(in_ready), 32'd0);
    chk("t1_load_rst", 32'(bsa_load), 32'd0);
    chk("t1_out_valid_rst", 32'(out_valid), 32'd0);
    RST = 1'b1;
    chk("t1_in_ready_release", 32'(in_ready), 32'd0);
    step();
    chk("t1_in_ready_edge", 32'(in_ready), 32'd1);

    // 15 + 15 with out_ready high.
    out_ready = 1'b1;
    accept_pair(4'd15, 4'd15);
    chk("t2_load_pulse", 32'(bsa_load), 32'd1);
    wait_out(got, lat);
    chk("t2_latency", 32'(lat), 32'd6);
    chk("t2_sum", 32'(got), 32'd30);

    // Back-to-back adds; in_ready low for WL+3 cycles each.
    accept_pair(4'd0, 4'd0);
    wait_out(got, lat);
    chk("t3_sum0", 32'(got), 32'd0);
    @(negedge CLK); #1;
    chk("t3_gap0", 32'(last_gap), 32'd7);
    accept_pair(4'd9, 4'd5);
    wait_out(got, lat);
    chk("t3_sum1", 32'(got), 32'd14);
    @(negedge CLK); #1;
    chk("t3_gap1", 32'(last_gap), 32'd7);

    // Backpressure with new operands offered while DONE stalls.
    out_ready = 1'b0;
    accept_pair(4'd7, 4'd1);
    wait_out(got, lat);
    chk("t4_sum_first", 32'(got), 32'd8);
    in_valid = 1'b1; a_in = 4'd2; b_in = 4'd3;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t4_sum_hold", 32'(sum), 32'd8);
      chk("t4_in_ready_hold", 32'(in_ready), 32'd0);
      chk("t4_load_hold", 32'(bsa_load), 32'd0);
    end
    out_ready = 1'b1;
    step();
    chk("t4_out_valid_drop", 32'(out_valid), 32'd0);
    chk("t4_in_ready_back", 32'(in_ready), 32'd1);
    step();
    chk("t4_next_load", 32'(bsa_load), 32'd1);
    in_valid = 1'b0;
    wait_out(got, lat);
    chk("t4_sum_next", 32'(got), 32'd5);

    // Reset after two serial bits of 3 + 3.
    accept_pair(4'd3, 4'd3);
    repeat (3) step();
    RST = 1'b0;
    #1;
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_sum", 32'(sum), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    step();
    RST = 1'b1;
    accept_pair(4'd2, 4'd2);
    wait_out(got, lat);
    chk("t5_sum_after", 32'(got), 32'd4);

    // Random pairs with random in_valid and out_ready.
    acc0 = n_acc; done0 = n_done; load0 = n_load;
    for (int i = 0; i < 200; i++) begin
      a_in = 4'($urandom_range(0, 15));
      b_in = 4'($urandom_range(0, 15));
      n = 0;
      acc = 1'b0;
      while (!acc && n < 100) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = 1'($urandom_range(0, 1));
        acc = in_valid && in_ready;
        step();
        n++;
      end
      chk("t6_accept", 32'(acc), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    chk("t6_drained", 32'(busy), 32'd0);
    chk("t6_accepts", 32'(n_acc - acc0), 32'd200);
    chk("t6_completions", 32'(n_done - done0), 32'(n_acc - acc0));
    chk("t6_loads", 32'(n_load - load0), 32'(n_acc - acc0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
